// File: rtl/demux_pkg.sv
// Shared types and constants for the demux select sequencer.
package demux_pkg;

  localparam int unsigned SEL_W_DEF = 3;
  localparam int unsigned NUM_CH    = 2 ** SEL_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_SWEEP  = 2'd1,
    MODE_CONT   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

endpackage

// File: rtl/dwell_timer.sv
// Down-counter that times the dwell on one channel; zero marks the last cycle.
module dwell_timer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] value,
  input  logic               dec,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DWELL_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/demux_sel_seq.sv
// Timed channel sequencer driving the d/s inputs of the 1:8 demux.
module demux_sel_seq
  import demux_pkg::*;
#(
  parameter int unsigned SEL_W   = SEL_W_DEF,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   chan,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               abort,
  input  logic               d_in,
  output logic               d,
  output logic [SEL_W-1:0]   s,
  output logic               busy,
  output logic               done,
  output logic               ch_strobe
);

  localparam logic [SEL_W:0] LAST_VISIT = (SEL_W + 1)'(2 ** SEL_W);

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [SEL_W-1:0]   s_q, s_d;
  logic [SEL_W:0]     visited_q, visited_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               stb_q, stb_d;
  logic               t_load, t_dec, t_zero;
  logic [DWELL_W-1:0] t_value;

  // A dwell of 0 behaves as 1, so the counter reload is max(v,1)-1.
  function automatic logic [DWELL_W-1:0] reload(input logic [DWELL_W-1:0] v);
    return (v == '0) ? '0 : v - DWELL_W'(1);
  endfunction

  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (t_load),
    .value (t_value),
    .dec   (t_dec),
    .zero  (t_zero)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    dwell_d   = dwell_q;
    s_d       = s_q;
    visited_d = visited_q;
    stb_d     = 1'b0;
    t_load    = 1'b0;
    t_dec     = 1'b0;
    t_value   = reload(dwell_q);

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_ACTIVE;
            mode_d    = mode_t'(mode);
            dwell_d   = dwell;
            s_d       = chan;
            visited_d = (SEL_W + 1)'(1);
            t_load    = 1'b1;
            t_value   = reload(dwell);
            stb_d     = 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (!t_zero) begin
            t_dec = 1'b1;
          end else if ((mode_q == MODE_CONT) ||
                       ((mode_q == MODE_SWEEP) && (visited_q != LAST_VISIT))) begin
            s_d       = s_q + SEL_W'(1);
            visited_d = visited_q + (SEL_W + 1)'(1);
            t_load    = 1'b1;
            stb_d     = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_ACTIVE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_SINGLE;
      dwell_q   <= '0;
      s_q       <= '0;
      visited_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      stb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      dwell_q   <= dwell_d;
      s_q       <= s_d;
      visited_q <= visited_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      stb_q     <= stb_d;
    end
  end

  assign d         = busy_q & d_in;
  assign s         = s_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ch_strobe = stb_q;

endmodule

// File: tb/tb_demux_sel_seq.sv
// Directed bench for demux_sel_seq driving a behavioural 1:8 demux (y = d << s).
module tb_demux_sel_seq;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, d_in;
  logic [1:0] mode;
  logic [2:0] chan;
  logic [7:0] dwell;
  logic       d, busy, done, ch_strobe;
  logic [2:0] s;
  logic [7:0] y;
  logic [13:0] obs, exp;
  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  demux_sel_seq #(.SEL_W(3), .DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .chan(chan),
    .dwell(dwell), .abort(abort), .d_in(d_in), .d(d), .s(s), .busy(busy),
    .done(done), .ch_strobe(ch_strobe)
  );

  assign y   = {7'b0, d} << s;
  assign obs = {busy, done, ch_strobe, s, y};

  task automatic start_op(input logic [1:0] m, input logic [2:0] c, input logic [7:0] dw);
    mode = m; chan = c; dwell = dw; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; d_in = 1'b1;
    mode = 2'd0; chan = 3'd0; dwell = 8'd0;
    repeat (2) @(negedge clk);
    exp = '0;
    vectors++;
    if (obs !== exp) begin
      errors++; $display("FAIL reset got %h want %h", obs, exp);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    d_in = 1'b1;
    start_op(2'd0, 3'd5, 8'd4);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      exp = {1'b1, 1'b0, (c == 0), 3'd5, 8'h20};
      vectors++;
      if (obs !== exp) begin
        errors++; $display("FAIL single c%0d got %h want %h", c, obs, exp);
      end
    end
    @(negedge clk);
    exp = {1'b0, 1'b1, 1'b0, 3'd5, 8'h00};
    vectors++;
    if (obs !== exp) begin
      errors++; $display("FAIL single_done got %h want %h", obs, exp);
    end
    @(negedge clk);
    exp = {1'b0, 1'b0, 1'b0, 3'd5, 8'h00};
    vectors++;
    if (obs !== exp) begin
      errors++; $display("FAIL single_idle got %h want %h", obs, exp);
    end
    // reserved mode behaves as single
    start_op(2'd3, 3'd1, 8'd1);
    exp = {1'b1, 1'b0, 1'b1, 3'd1, 8'h02};
    vectors++;
    if (obs !== exp) begin
      errors++; $display("FAIL rsvd_active got %h want %h", obs, exp);
    end
    @(negedge clk);
    exp = {1'b0, 1'b1, 1'b0, 3'd1, 8'h00};
    vectors++;
    if (obs !== exp) begin
      errors++; $display("FAIL rsvd_done got %h want %h", obs, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep_once();
    int strobes = 0;
    logic [2:0] ch;
    d_in = 1'b1;
    start_op(2'd1, 3'd0, 8'd3);
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      ch = 3'(c / 3);
      exp = {1'b1, 1'b0, (c % 3 == 0), ch, 8'h01 << ch};
      strobes += int'(ch_strobe);
      vectors++;
      if (obs !== exp) begin
        errors++; $display("FAIL sweep c%0d got %h want %h", c, obs, exp);
      end
    end
    vectors++;
    if (strobes !== 8) begin
      errors++; $display("FAIL sweep_strobes got %0d want 8", strobes);
    end
    @(negedge clk);
    exp = {1'b0, 1'b1, 1'b0, 3'd7, 8'h00};
    vectors++;
    if (obs !== exp) begin
      errors++; $display("FAIL sweep_done got %h want %h", obs, exp);
    end
    @(negedge clk);
    exp = {1'b0, 1'b0, 1'b0, 3'd7, 8'h00};
    vectors++;
    if (obs !== exp) begin
      errors++; $display("FAIL sweep_idle got %h want %h", obs, exp);
    end
  endtask

  task automatic test_wrap();
    logic [2:0] ch;
    d_in = 1'b1;
    start_op(2'd1, 3'd6, 8'd1);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      ch = 3'(6 + c);
      exp = {1'b1, 1'b0, 1'b1, ch, 8'h01 << ch};
      vectors++;
      if (obs !== exp) begin
        errors++; $display("FAIL wrap c%0d got %h want %h", c, obs, exp);
      end
    end
    @(negedge clk);
    exp = {1'b0, 1'b1, 1'b0, 3'd5, 8'h00};
    vectors++;
    if (obs !== exp) begin
      errors++; $display("FAIL wrap_done got %h want %h", obs, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_continuous_abort();
    logic [2:0] ch;
    start_op(2'd2, 3'd0, 8'd0);
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      d_in = c[0];
      #1;
      ch = 3'(c);
      exp = {1'b1, 1'b0, 1'b1, ch, {7'b0, d_in} << ch};
      vectors++;
      if (obs !== exp) begin
        errors++; $display("FAIL cont c%0d got %h want %h", c, obs, exp);
      end
    end
    d_in = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exp = {1'b0, 1'b0, 1'b0, 3'd3, 8'h00};
    vectors++;
    if (obs !== exp) begin
      errors++; $display("FAIL abort got %h want %h", obs, exp);
    end
    @(negedge clk);
    vectors++;
    if (obs !== exp) begin
      errors++; $display("FAIL abort_nodone got %h want %h", obs, exp);
    end
  endtask

  task automatic test_ignored_start_abort_priority();
    logic [2:0] ch;
    d_in = 1'b1;
    start_op(2'd1, 3'd2, 8'd2);
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      ch = 3'(2 + c / 2);
      exp = {1'b1, 1'b0, (c % 2 == 0), ch, 8'h01 << ch};
      vectors++;
      if (obs !== exp) begin
        errors++; $display("FAIL ignstart c%0d got %h want %h", c, obs, exp);
      end
      if (c == 5) begin
        start = 1'b1; mode = 2'd0; chan = 3'd0; dwell = 8'd7;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    exp = {1'b0, 1'b1, 1'b0, 3'd1, 8'h00};
    vectors++;
    if (obs !== exp) begin
      errors++; $display("FAIL ignstart_done got %h want %h", obs, exp);
    end
    @(negedge clk);
    start = 1'b1; abort = 1'b1; mode = 2'd1; chan = 3'd4; dwell = 8'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    exp = {1'b0, 1'b0, 1'b0, 3'd1, 8'h00};
    vectors++;
    if (obs !== exp) begin
      errors++; $display("FAIL start_abort got %h want %h", obs, exp);
    end
    @(negedge clk);
    vectors++;
    if (obs !== exp) begin
      errors++; $display("FAIL start_abort_hold got %h want %h", obs, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] ch;
    d_in = 1'b1;
    start_op(2'd1, 3'd0, 8'd3);
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge clk);
      ch = 3'(c / 3);
      exp = {1'b1, 1'b0, (c % 3 == 0), ch, 8'h01 << ch};
      vectors++;
      if (obs !== exp) begin
        errors++; $display("FAIL rstmid c%0d got %h want %h", c, obs, exp);
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp = '0;
    vectors++;
    if (obs !== exp) begin
      errors++; $display("FAIL rstmid_reset got %h want %h", obs, exp);
    end
    start_op(2'd0, 3'd2, 8'd2);
    for (int c = 0; c < 2; c++) begin
      if (c > 0) @(negedge clk);
      exp = {1'b1, 1'b0, (c == 0), 3'd2, 8'h04};
      vectors++;
      if (obs !== exp) begin
        errors++; $display("FAIL rstmid_fresh c%0d got %h want %h", c, obs, exp);
      end
    end
    @(negedge clk);
    exp = {1'b0, 1'b1, 1'b0, 3'd2, 8'h00};
    vectors++;
    if (obs !== exp) begin
      errors++; $display("FAIL rstmid_done got %h want %h", obs, exp);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep_once();
    test_wrap();
    test_continuous_abort();
    test_ignored_start_abort_priority();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
